// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_R,
        CLS_I
    } alu_class_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0111;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller-to-datapath bundle: decoded instruction fields and status in,
// mux selects and enables out. The controller side is the master.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output alu_sel, alu_src_a, alu_src_b, result_src, adr_src,
               mem_read, mem_write, ir_write, reg_write, pc_write,
               instr_done, illegal
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  alu_sel, alu_src_a, alu_src_b, result_src, adr_src,
               mem_read, mem_write, ir_write, reg_write, pc_write,
               instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode for R-type and I-ALU execute states;
// flags funct3 values the datapath does not implement.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  alu_class_t cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_sel_o,
    output logic       funct_illegal_o
);

    always_comb begin
        alu_sel_o       = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (cls_i)
            CLS_R: begin
                case (funct3_i)
                    3'b000:  alu_sel_o = funct7_5_i ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_sel_o = ALU_AND;
                    3'b110:  alu_sel_o = ALU_OR;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            CLS_I: begin
                // funct7_5 is immediate data for I-ALU, so it never selects SUB here
                case (funct3_i)
                    3'b000:  alu_sel_o = ALU_ADD;
                    3'b111:  alu_sel_o = ALU_AND;
                    3'b110:  alu_sel_o = ALU_OR;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: Moore outputs per state, with the
// fetch/memory enables qualified by mem_ready and the branch PC write by zero.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    state_t     state_q, state_d;
    alu_class_t alu_cls;
    logic [3:0] dec_alu_sel;
    logic       dec_illegal;

    assign alu_cls = (state_q == S_EXEC_R) ? CLS_R :
                     (state_q == S_EXEC_I) ? CLS_I : CLS_NONE;

    alu_decoder u_alu_decoder (
        .cls_i           (alu_cls),
        .funct3_i        (bus.funct3),
        .funct7_5_i      (bus.funct7_5),
        .alu_sel_o       (dec_alu_sel),
        .funct_illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.alu_sel    = ALU_ADD;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.result_src = RES_ALUOUT;
        bus.adr_src    = ADR_PC;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.pc_write   = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.adr_src    = ADR_PC;
                bus.mem_read   = 1'b1;
                bus.alu_src_a  = SRCA_PC;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.adr_src    = ADR_RESULT;
                bus.result_src = RES_ALUOUT;
                bus.mem_read   = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_MEMDATA;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.adr_src    = ADR_RESULT;
                bus.result_src = RES_ALUOUT;
                bus.mem_write  = 1'b1;
                bus.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = (state_q == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                bus.alu_sel   = dec_alu_sel;
                state_d       = dec_illegal ? S_ILLEGAL : S_ALUWB;
            end
            S_ALUWB: begin
                bus.result_src = RES_ALUOUT;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a  = SRCA_RS1;
                bus.alu_src_b  = SRCB_RS2;
                bus.alu_sel    = ALU_SUB;
                bus.result_src = RES_ALUOUT;
                bus.pc_write   = bus.zero;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a  = SRCA_OLDPC;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALUOUT;
                bus.pc_write   = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_ILLEGAL: begin
                bus.illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 opcode  input  7  instruction[6:0] from the instruction register.
REQ-004 funct3  input  3  instruction[14:12].
REQ-005 funct7_5  input  1  instruction[30].
REQ-006 zero  input  1  ALU zero flag from the current cycle's result.
REQ-007 mem_ready  input  1  memory handshake; the access completes in a cycle where the request is high and mem_ready=1.
REQ-008 alu_sel  output  4  ALU operation: 0000 ADD, 1000 SUB, 0110 AND, 0111 OR.
REQ-009 alu_src_a  output  2  ALU A operand: 00 PC, 01 old PC, 10 rs1.
REQ-010 alu_src_b  output  2  ALU B operand: 00 rs2, 01 immediate, 10 constant 4.
REQ-011 result_src  output  2  result bus: 00 ALU-out register, 01 memory data, 10 live ALU result.
REQ-012 adr_src  output  1  memory address: 0 PC, 1 result bus.
REQ-013 mem_read, mem_write, ir_write, reg_write, pc_write  output  1 each  enables/requests.
REQ-014 instr_done  output  1  one-cycle retire pulse.
REQ-015 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-016 Supported opcodes: LW 0000011, SW 0100011, R-type 0110011, I-ALU 0010011, BEQ 1100011, JAL 1101111. Any other opcode in DECODE goes to ILLEGAL.
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BEQ, JAL, ILLEGAL. Outputs are Moore, except enables qualified by mem_ready or zero.
REQ-018 FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_sel=ADD, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01, alu_sel=ADD (branch target). Next state by opcode: LW/SW→MEMADR, R→EXEC_R, I-ALU→EXEC_I, BEQ→BEQ, JAL→JAL.
REQ-020 MEMADR: alu_src_a=10, alu_src_b=01, ADD. Next: LW→MEMRD, SW→MEMWR.
REQ-021 MEMRD: adr_src=1, result_src=00, mem_read=1. Hold until mem_ready, then go to MEMWB.
REQ-022 MEMWB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
REQ-023 MEMWR: adr_src=1, result_src=00, mem_write=1. Hold until mem_ready. On mem_ready: instr_done=1, next FETCH.
REQ-024 EXEC_R: alu_src_a=10, alu_src_b=00. ALU decode by funct3:
  - 000 with funct7_5=1 → SUB; 000 with funct7_5=0 → ADD
  - 111 → AND; 110 → OR
  - any other funct3 → ILLEGAL instead of ALUWB.
REQ-025 EXEC_I: alu_src_a=10, alu_src_b=01. ALU decode by funct3:
  - 000 → ADD (funct7_5 ignored); 111 → AND; 110 → OR
  - any other funct3 → ILLEGAL.
REQ-026 ALUWB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
REQ-027 BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero, instr_done=1. Next: FETCH.
REQ-028 JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1, reg_write=1, instr_done=1. Next: FETCH.
REQ-029 ILLEGAL: illegal=1 and all enables 0; the state is terminal until rst.
REQ-030 In every state, any enable not listed is 0, and alu_sel defaults to ADD.
REQ-031 mem_read and mem_write are never asserted together. Each handshake state holds all outputs stable while waiting.
REQ-032 Cycle count with zero wait states: LW 5, SW 4, R/I 4, BEQ 3, JAL 3.

Reset
REQ-033 When rst=1 at a clock edge: state=FETCH, illegal=0, all outputs take FETCH values on the next cycle. This applies mid-instruction, including during a pending memory wait.
REQ-034 rst has priority over every transition, including from ILLEGAL.

Structure
REQ-035 A shared package holds: state enum, opcode constants, alu_sel codes, and the src/result mux encodings. The datapath and the ALU import the same alu_sel codes.
REQ-036 One sub-module, alu_decoder, is combinational and maps (state class, funct3, funct7_5) to alu_sel plus a funct-illegal flag.

Verification
REQ-037 Instruction add (R, funct3 000, funct7_5 0), mem_ready=1 → alu_sel 0000 in EXEC_R; reg_write and instr_done high in cycle 4.
REQ-038 Instruction sub (funct7_5 1) → alu_sel 1000; instruction or → 0111; instruction andi → 0110.
REQ-039 LW with mem_ready held low for 3 cycles in MEMRD → outputs stable while waiting; MEMWB is reached one cycle after mem_ready; 8 cycles total.
REQ-040 BEQ with zero=1 → pc_write=1 in BEQ. BEQ with zero=0 → pc_write=0. Both cases retire in 3 cycles.
REQ-041 Opcode 1110011 → ILLEGAL, illegal=1, no enables asserted for 10 cycles; rst pulse → FETCH and illegal=0.
REQ-042 rst asserted during a MEMWR wait → mem_write=0 and state FETCH on the next cycle.
